// File: rtl/wb_pkg.sv
// Shared types for the write-back stage and the units that reuse its load extender.
package wb_pkg;

   // Write-back source select
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2,
      WB_RSVD = 2'd3
   } wb_src_t;

   // Load access size
   typedef enum logic [1:0] {
      LD_B = 2'd0,
      LD_H = 2'd1,
      LD_W = 2'd2,
      LD_D = 2'd3
   } ld_size_t;

   // Number of meaningful load bits for a given size
   function automatic int ld_bits(input ld_size_t size);
      int bits;
      case (size)
         LD_B:    bits = 8;
         LD_H:    bits = 16;
         LD_W:    bits = 32;
         LD_D:    bits = 64;
         default: bits = 64;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/wb_load_extend.sv
// Combinational size/sign extension of right-aligned load data.
// Any size whose width reaches DATA_W passes the data through unchanged.
module wb_load_extend
   import wb_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] i_mem_data,
   input  ld_size_t          i_ld_size,
   input  logic              i_ld_signed,
   output logic [DATA_W-1:0] o_ext_data
);

   logic [DATA_W-1:0] w_byte;
   logic [DATA_W-1:0] w_half;
   logic [DATA_W-1:0] w_word;

   assign w_byte = {{(DATA_W-8){i_ld_signed & i_mem_data[7]}},   i_mem_data[7:0]};
   assign w_half = {{(DATA_W-16){i_ld_signed & i_mem_data[15]}}, i_mem_data[15:0]};

   // A 32-bit datapath has no room above a word, so the word form is a pass-through there
   generate
      if (DATA_W > 32) begin : g_word_ext
         assign w_word = {{(DATA_W-32){i_ld_signed & i_mem_data[31]}}, i_mem_data[31:0]};
      end else begin : g_word_full
         assign w_word = i_mem_data;
      end
   endgenerate

   // Pick the extended form matching the access size
   always_comb begin
      o_ext_data = i_mem_data;
      case (i_ld_size)
         LD_B:    o_ext_data = w_byte;
         LD_H:    o_ext_data = w_half;
         LD_W:    o_ext_data = w_word;
         LD_D:    o_ext_data = i_mem_data;
         default: o_ext_data = i_mem_data;
      endcase
   end

endmodule

// File: rtl/writeback_stage_buffered.sv
// Write-back stage: selects the result source, extends load data and queues
// completed register writes until the register-file port is free. Also offers
// a forwarding lookup over the queued writes and a saturating retire counter.
module writeback_stage_buffered
   import wb_pkg::*;
#(
   parameter  int DATA_W     = 64,
   parameter  int REG_ADDR_W = 5,
   parameter  int DEPTH      = 2,
   parameter  int ZERO_REG   = 31,
   parameter  int CNT_W      = 16,
   localparam int OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  wb_src_t               in_src_sel,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_mem_data,
   input  logic [DATA_W-1:0]     in_link_addr,
   input  ld_size_t              in_ld_size,
   input  logic                  in_ld_signed,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  flush,
   input  logic                  wb_ready,
   output logic                  rf_wr_en,
   output logic [REG_ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0]     rf_wr_data,
   input  logic [REG_ADDR_W-1:0] fwd_rs,
   output logic                  fwd_hit,
   output logic [DATA_W-1:0]     fwd_data,
   output logic [OCC_W-1:0]      count,
   output logic [CNT_W-1:0]      retired
);

   localparam int                    PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [REG_ADDR_W-1:0] ZR_ADDR   = REG_ADDR_W'(ZERO_REG);
   localparam logic [PTR_W-1:0]      PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0]      OCC_ZERO  = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0]      OCC_ONE   = OCC_W'(1);
   localparam logic [OCC_W-1:0]      OCC_FULL  = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0]      RET_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      RET_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]      RET_MAX   = {CNT_W{1'b1}};
   localparam logic [DATA_W-1:0]     DATA_ZERO = {DATA_W{1'b0}};
   localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = {REG_ADDR_W{1'b0}};

   logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
   logic [DATA_W-1:0]     r_data [DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [OCC_W-1:0]      r_count;
   logic [CNT_W-1:0]      r_retired;

   logic [DATA_W-1:0]     w_ext_data;
   logic [DATA_W-1:0]     w_wb_data;
   logic                  w_ready;
   logic                  w_not_empty;
   logic                  w_store;
   logic                  w_deq;
   logic                  w_fwd_hit;
   logic [DATA_W-1:0]     w_fwd_data;

   // Pointer increment with wrap for non-power-of-two depths
   function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = PTR_ZERO;
      end else begin
         nxt = ptr + PTR_ONE;
      end
      return nxt;
   endfunction

   // Physical slot that sits 'off' entries after 'base' in queue order
   function automatic logic [PTR_W-1:0] f_slot(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= DEPTH) begin
         s = s - DEPTH;
      end else begin
         s = s;
      end
      return PTR_W'(s);
   endfunction

   wb_load_extend #(
      .DATA_W (DATA_W)
   ) u_load_extend (
      .i_mem_data  (in_mem_data),
      .i_ld_size   (in_ld_size),
      .i_ld_signed (in_ld_signed),
      .o_ext_data  (w_ext_data)
   );

   // Choose the value that will be written back; the reserved code behaves as ALU
   always_comb begin
      w_wb_data = in_alu_result;
      case (in_src_sel)
         WB_ALU:  w_wb_data = in_alu_result;
         WB_MEM:  w_wb_data = w_ext_data;
         WB_LINK: w_wb_data = in_link_addr;
         WB_RSVD: w_wb_data = in_alu_result;
         default: w_wb_data = in_alu_result;
      endcase
   end

   // Handshake depends on registered occupancy only, never on wb_ready
   assign w_ready     = (r_count < OCC_FULL);
   assign w_not_empty = (r_count != OCC_ZERO);
   assign w_store     = in_valid & w_ready & in_reg_write & (in_rd != ZR_ADDR);
   assign w_deq       = w_not_empty & wb_ready;

   // Queue storage, pointers and occupancy; flush drops everything including a same-cycle enqueue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= PTR_ZERO;
         r_rptr  <= PTR_ZERO;
         r_count <= OCC_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= ADDR_ZERO;
            r_data[i] <= DATA_ZERO;
         end
      end else if (flush) begin
         r_wptr  <= PTR_ZERO;
         r_rptr  <= PTR_ZERO;
         r_count <= OCC_ZERO;
      end else begin
         if (w_store) begin
            r_rd[r_wptr]   <= in_rd;
            r_data[r_wptr] <= w_wb_data;
            r_wptr         <= f_next_ptr(r_wptr);
         end
         if (w_deq) begin
            r_rptr <= f_next_ptr(r_rptr);
         end
         case ({w_store, w_deq})
            2'b10:   r_count <= r_count + OCC_ONE;
            2'b01:   r_count <= r_count - OCC_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating count of register writes handed to the register file
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired <= RET_ZERO;
      end else if (w_deq && (r_retired != RET_MAX)) begin
         r_retired <= r_retired + RET_ONE;
      end else begin
         r_retired <= r_retired;
      end
   end

   // Forwarding search, oldest to youngest so the youngest match is left standing
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = DATA_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < int'(r_count)) && (fwd_rs != ZR_ADDR) &&
             (r_rd[f_slot(r_rptr, i)] == fwd_rs)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[f_slot(r_rptr, i)];
         end else begin
            w_fwd_hit  = w_fwd_hit;
            w_fwd_data = w_fwd_data;
         end
      end
   end

   assign in_ready   = w_ready;
   assign rf_wr_en   = w_deq;
   assign rf_wr_addr = w_not_empty ? r_rd[r_rptr]   : ADDR_ZERO;
   assign rf_wr_data = w_not_empty ? r_data[r_rptr] : DATA_ZERO;
   assign fwd_hit    = w_fwd_hit;
   assign fwd_data   = w_fwd_data;
   assign count      = r_count;
   assign retired    = r_retired;

endmodule

// File: tb/tb_writeback_stage_buffered.sv
// Bench for writeback_stage_buffered: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_writeback_stage_buffered;
   import wb_pkg::*;

   localparam int DW     = 64;
   localparam int AW     = 5;
   localparam int DEPTH  = 2;
   localparam int CW     = 4;
   localparam int NB     = 2;
   localparam int RETMAX = 15;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic           in_reg_write;
   wb_src_t        in_src_sel;
   logic [DW-1:0]  in_alu_result;
   logic [DW-1:0]  in_mem_data;
   logic [DW-1:0]  in_link_addr;
   ld_size_t       in_ld_size;
   logic           in_ld_signed;
   logic [AW-1:0]  in_rd;
   logic           flush;
   logic           wb_ready;
   logic           rf_wr_en;
   logic [AW-1:0]  rf_wr_addr;
   logic [DW-1:0]  rf_wr_data;
   logic [AW-1:0]  fwd_rs;
   logic           fwd_hit;
   logic [DW-1:0]  fwd_data;
   logic [NB-1:0]  count;
   logic [CW-1:0]  retired;

   writeback_stage_buffered #(
      .DATA_W(DW), .REG_ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(31), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg_write(in_reg_write), .in_src_sel(in_src_sel),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
      .in_link_addr(in_link_addr), .in_ld_size(in_ld_size),
      .in_ld_signed(in_ld_signed), .in_rd(in_rd), .flush(flush),
      .wb_ready(wb_ready), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
      .rf_wr_data(rf_wr_data), .fwd_rs(fwd_rs), .fwd_hit(fwd_hit),
      .fwd_data(fwd_data), .count(count), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t mq[$];
   int   m_ret = 0;

   logic          e_ready, e_en, e_hit;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data, e_fdata;
   logic [NB-1:0] e_count;
   logic [CW-1:0] e_ret;

   // Reference load extension from the size/sign rules
   function automatic logic [DW-1:0] ref_load(input logic [DW-1:0] mem, input int size, input logic sgn);
      int w;
      logic [DW-1:0] mask;
      logic [DW-1:0] v;
      w = 8 << size;
      if (w >= DW) return mem;
      mask = (64'd1 << w) - 64'd1;
      v = mem & mask;
      if (sgn && mem[w-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [DW-1:0] ref_wb();
      case (int'(in_src_sel))
         1:       return ref_load(in_mem_data, int'(in_ld_size), in_ld_signed);
         2:       return in_link_addr;
         default: return in_alu_result;
      endcase
   endfunction

   task automatic model_expect();
      e_ready = (mq.size() < DEPTH);
      e_count = NB'(mq.size());
      e_en    = (mq.size() > 0) && wb_ready;
      e_addr  = (mq.size() > 0) ? mq[0].rd : 5'd0;
      e_data  = (mq.size() > 0) ? mq[0].data : 64'd0;
      e_hit   = 1'b0;
      e_fdata = 64'd0;
      if (fwd_rs != 5'd31) begin
         for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].rd == fwd_rs) begin
               e_hit   = 1'b1;
               e_fdata = mq[k].data;
               break;
            end
         end
      end
      e_ret = CW'(m_ret);
   endtask

   task automatic model_edge();
      bit deq;
      bit acc;
      deq = (mq.size() > 0) && wb_ready;
      acc = in_valid && (mq.size() < DEPTH);
      if (deq) begin
         void'(mq.pop_front());
         if (m_ret < RETMAX) m_ret++;
      end
      if (flush) mq.delete();
      else if (acc && in_reg_write && in_rd != 5'd31) mq.push_back('{rd: in_rd, data: ref_wb()});
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0; in_reg_write = 1'b0; in_src_sel = WB_ALU;
      in_alu_result = 64'd0; in_mem_data = 64'd0; in_link_addr = 64'd0;
      in_ld_size = LD_B; in_ld_signed = 1'b0; in_rd = 5'd0; flush = 1'b0;
      fwd_rs = 5'd0;
   endtask

   task automatic enq(input logic [AW-1:0] rd, input logic [DW-1:0] val);
      in_valid = 1'b1; in_reg_write = 1'b1; in_src_sel = WB_ALU;
      in_alu_result = val; in_rd = rd;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0; in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd4; wb_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (count !== 2'd0)    begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %0b want 0", rf_wr_en); end
      n_cmp++; if (rf_wr_addr !== 5'd0 || rf_wr_data !== 64'd0) begin n_bad++; $display("FAIL reset_wr_bus: got %0d/%h want 0/0", rf_wr_addr, rf_wr_data); end
      n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin n_bad++; $display("FAIL reset_fwd: got %0b/%h want 0/0", fwd_hit, fwd_data); end
      n_cmp++; if (retired !== 4'd0)  begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
      idle();
      #2 reset = 1'b1;
      mq.delete(); m_ret = 0;
      @(negedge clk);
   endtask

   task automatic test_alu_write();
      wb_ready = 1'b1;
      enq(5'd3, 64'h1234);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alu_in_ready: got %0b want 1", in_ready); end
      n_cmp++; if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL alu_no_passthru: got %0b want 0", rf_wr_en); end
      tick();
      idle();
      #1;
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 64'h1234)
         begin n_bad++; $display("FAIL alu_write: got %0b/%0d/%h want 1/3/1234", rf_wr_en, rf_wr_addr, rf_wr_data); end
      tick();
      #1;
      n_cmp++; if (retired !== 4'd1) begin n_bad++; $display("FAIL alu_retired: got %0d want 1", retired); end
      n_cmp++; if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL alu_drained: got %0b want 0", rf_wr_en); end
   endtask

   task automatic test_src_select();
      logic [DW-1:0] mem_t [8] = '{64'h80F0, 64'h80F0, 64'h80F0, 64'h1234_5678_8000_0001,
                                   64'h1234_5678_8000_0001, 64'h80F0, 64'h5, 64'h5};
      int            siz_t [8] = '{0, 1, 1, 2, 3, 0, 0, 0};
      logic          sgn_t [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int            src_t [8] = '{1, 1, 1, 1, 1, 1, 2, 3};
      logic [DW-1:0] exp_t [8] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_80F0, 64'h0000_0000_0000_80F0,
                                   64'hFFFF_FFFF_8000_0001, 64'h1234_5678_8000_0001, 64'h0000_0000_0000_00F0,
                                   64'h0000_0000_DEAD_BEE4, 64'h0000_0000_0000_0ABC};
      wb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd10;
         in_src_sel = wb_src_t'(src_t[i]); in_mem_data = mem_t[i];
         in_ld_size = ld_size_t'(siz_t[i]); in_ld_signed = sgn_t[i];
         in_link_addr = 64'hDEAD_BEE4; in_alu_result = 64'hABC;
         tick();
         idle();
         #1;
         n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_data !== exp_t[i])
            begin n_bad++; $display("FAIL src_case%0d: got %0b/%h want 1/%h", i, rf_wr_en, rf_wr_data, exp_t[i]); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      wb_ready = 1'b0;
      enq(5'd1, 64'h11);
      tick();
      enq(5'd2, 64'h22);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_half: got %0b want 1", in_ready); end
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 2'd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %0d/%0b want 2/0", count, in_ready); end
      n_cmp++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd1) begin n_bad++; $display("FAIL bp_hold: got %0b/%0d want 0/1", rf_wr_en, rf_wr_addr); end
      wb_ready = 1'b1;
      #1;
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd1 || rf_wr_data !== 64'h11)
         begin n_bad++; $display("FAIL bp_first: got %0b/%0d/%h want 1/1/11", rf_wr_en, rf_wr_addr, rf_wr_data); end
      tick();
      #1;
      n_cmp++; if (in_ready !== 1'b1 || count !== 2'd1 || rf_wr_addr !== 5'd2 || rf_wr_data !== 64'h22)
         begin n_bad++; $display("FAIL bp_second: got %0b/%0d/%0d/%h want 1/1/2/22", in_ready, count, rf_wr_addr, rf_wr_data); end
      tick();
      #1;
      n_cmp++; if (count !== 2'd0 || rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %0d/%0b want 0/0", count, rf_wr_en); end
   endtask

   task automatic test_discard();
      logic [CW-1:0] ret_exp;
      ret_exp = CW'(m_ret);
      wb_ready = 1'b1;
      enq(5'd31, 64'h99);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL discard_ready: got %0b want 1", in_ready); end
      tick();
      enq(5'd5, 64'h55);
      in_reg_write = 1'b0;
      #1;
      n_cmp++; if (count !== 2'd0 || rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL discard_xzr: got %0d/%0b want 0/0", count, rf_wr_en); end
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 2'd0 || rf_wr_en !== 1'b0 || retired !== ret_exp)
         begin n_bad++; $display("FAIL discard_nowr: got %0d/%0b/%0d want 0/0/%0d", count, rf_wr_en, retired, ret_exp); end
   endtask

   task automatic test_forwarding();
      wb_ready = 1'b0;
      enq(5'd7, 64'hAA);
      fwd_rs = 5'd7;
      #1;
      n_cmp++; if (fwd_hit !== 1'b0) begin n_bad++; $display("FAIL fwd_enq_invisible: got %0b want 0", fwd_hit); end
      tick();
      enq(5'd7, 64'hBB);
      fwd_rs = 5'd7;
      #1;
      n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 64'hAA) begin n_bad++; $display("FAIL fwd_one: got %0b/%h want 1/aa", fwd_hit, fwd_data); end
      tick();
      idle();
      fwd_rs = 5'd7;
      #1;
      n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 64'hBB) begin n_bad++; $display("FAIL fwd_youngest: got %0b/%h want 1/bb", fwd_hit, fwd_data); end
      fwd_rs = 5'd8;
      #1;
      n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin n_bad++; $display("FAIL fwd_miss: got %0b/%h want 0/0", fwd_hit, fwd_data); end
      fwd_rs = 5'd31;
      #1;
      n_cmp++; if (fwd_hit !== 1'b0) begin n_bad++; $display("FAIL fwd_xzr: got %0b want 0", fwd_hit); end
      wb_ready = 1'b1;
      fwd_rs = 5'd7;
      tick();
      #1;
      n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 64'hBB) begin n_bad++; $display("FAIL fwd_after_pop: got %0b/%h want 1/bb", fwd_hit, fwd_data); end
      tick();
      #1;
      n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin n_bad++; $display("FAIL fwd_drained: got %0b/%h want 0/0", fwd_hit, fwd_data); end
   endtask

   task automatic test_flush();
      int ret_exp;
      wb_ready = 1'b0;
      enq(5'd4, 64'h44); tick();
      enq(5'd5, 64'h55); tick();
      enq(5'd6, 64'h66);
      flush = 1'b1;
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_full: got %0d/%0b want 0/1", count, in_ready); end
      wb_ready = 1'b1;
      #1;
      n_cmp++; if (rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL flush_lost: got %0b want 0", rf_wr_en); end
      wb_ready = 1'b0;
      enq(5'd8, 64'h88); tick();
      enq(5'd9, 64'h99);
      flush = 1'b1; wb_ready = 1'b1;
      ret_exp = (m_ret < RETMAX) ? m_ret + 1 : RETMAX;
      #1;
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd8) begin n_bad++; $display("FAIL flush_deq: got %0b/%0d want 1/8", rf_wr_en, rf_wr_addr); end
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 2'd0 || rf_wr_en !== 1'b0 || retired !== CW'(ret_exp))
         begin n_bad++; $display("FAIL flush_enq_drop: got %0d/%0b/%0d want 0/0/%0d", count, rf_wr_en, retired, ret_exp); end
   endtask

   task automatic test_reset_async();
      wb_ready = 1'b0;
      enq(5'd12, 64'hC0); tick();
      enq(5'd13, 64'hD0); tick();
      idle();
      wb_ready = 1'b1;
      #1;
      n_cmp++; if (rf_wr_en !== 1'b1) begin n_bad++; $display("FAIL async_pre: got %0b want 1", rf_wr_en); end
      #1 reset = 1'b0;
      #1;
      n_cmp++; if (rf_wr_en !== 1'b0 || count !== 2'd0 || retired !== 4'd0)
         begin n_bad++; $display("FAIL async_reset: got %0b/%0d/%0d want 0/0/0", rf_wr_en, count, retired); end
      n_cmp++; if (rf_wr_addr !== 5'd0 || rf_wr_data !== 64'd0) begin n_bad++; $display("FAIL async_bus: got %0d/%h want 0/0", rf_wr_addr, rf_wr_data); end
      mq.delete(); m_ret = 0;
      #1 reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [141:0] got;
      logic [141:0] exp;
      for (int c = 0; c < 600; c++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         in_reg_write  = ($urandom_range(0, 4) != 0);
         in_src_sel    = wb_src_t'($urandom_range(0, 3));
         in_alu_result = {$urandom, $urandom};
         in_mem_data   = {$urandom, $urandom};
         in_link_addr  = {$urandom, $urandom};
         in_ld_size    = ld_size_t'($urandom_range(0, 3));
         in_ld_signed  = 1'($urandom_range(0, 1));
         in_rd         = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
         flush         = ($urandom_range(0, 24) == 0);
         wb_ready      = 1'($urandom_range(0, 1));
         fwd_rs        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
         #1;
         model_expect();
         got = {in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_hit, fwd_data, count, retired};
         exp = {e_ready, e_en, e_addr, e_data, e_hit, e_fdata, e_count, e_ret};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL random_cycle%0d: got %h want %h", c, got, exp);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      reset = 1'b0;
      wb_ready = 1'b0;
      idle();
      test_reset();
      test_alu_write();
      test_src_select();
      test_backpressure();
      test_discard();
      test_forwarding();
      test_flush();
      test_reset_async();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
